// File: rtl/load_store_unit_pkg.sv
// Shared constants for the load/store unit: data width, access sizes, FSM states.
// Also holds the lane-mask and alignment helpers used by the top level.
package load_store_unit_pkg;

  localparam int WORD = 64;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;
  localparam logic [1:0] SIZE_D = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } lsu_state_e;

  function automatic logic [7:0] size_mask(input logic [1:0] size);
    case (size)
      SIZE_B:  return 8'h01;
      SIZE_H:  return 8'h03;
      SIZE_W:  return 8'h0F;
      default: return 8'hFF;
    endcase
  endfunction

  function automatic logic misaligned(input logic [1:0] size, input logic [2:0] off);
    case (size)
      SIZE_B:  return 1'b0;
      SIZE_H:  return off[0];
      SIZE_W:  return |off[1:0];
      default: return |off;
    endcase
  endfunction

endpackage

// File: rtl/load_store_unit_extract.sv
// load_extract: right-aligns the addressed bytes of a read doubleword and
// masks them to the access size with sign or zero extension. Purely combinational.
module load_extract
  import load_store_unit_pkg::*;
(
  input  logic [WORD-1:0] mem_rdata,
  input  logic [2:0]      offset,
  input  logic [1:0]      size,
  input  logic            sign_ext,
  output logic [WORD-1:0] load_data
);

  logic [WORD-1:0] shifted;

  assign shifted = mem_rdata >> {offset, 3'b000};

  always_comb begin
    load_data = shifted;
    case (size)
      SIZE_B:  load_data = {{56{sign_ext & shifted[7]}},  shifted[7:0]};
      SIZE_H:  load_data = {{48{sign_ext & shifted[15]}}, shifted[15:0]};
      SIZE_W:  load_data = {{32{sign_ext & shifted[31]}}, shifted[31:0]};
      default: load_data = shifted;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: one bus access per accepted start, with byte-lane steering, load extension and a bus timeout.
// Defining LSU_ALIGN_CHECK_EN traps misaligned accesses (fault + done) without issuing a bus request.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            is_store,
  input  logic [1:0]      size,
  input  logic            sign_ext,
  input  logic [WORD-1:0] addr,
  input  logic [WORD-1:0] store_data,
  output logic            mem_req,
  output logic            mem_we,
  output logic [WORD-1:0] mem_addr,
  output logic [7:0]      mem_be,
  output logic [WORD-1:0] mem_wdata,
  input  logic [WORD-1:0] mem_rdata,
  input  logic            mem_ack,
  output logic            busy,
  output logic            done,
  output logic            fault,
  output logic [WORD-1:0] load_data
);

  localparam int            CW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  lsu_state_e      state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            fault_q, fault_d;
  logic            is_store_q, sign_ext_q;
  logic [1:0]      size_q;
  logic [2:0]      off_q;
  logic [WORD-1:0] mem_addr_q, mem_wdata_q, load_data_q, ext_data;
  logic [7:0]      mem_be_q;
  logic            accept, ack_ok, timeout, trap;

`ifdef LSU_ALIGN_CHECK_EN
  assign trap = misaligned(size, addr[2:0]);
`else
  assign trap = 1'b0;
`endif

  // Ack is checked before the counter so a last-cycle ack still completes cleanly.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    fault_d = fault_q;
    accept  = 1'b0;
    ack_ok  = 1'b0;
    timeout = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          accept  = 1'b1;
          cnt_d   = '0;
          fault_d = trap;
          state_d = trap ? RESP : REQ;
        end
      end
      REQ: begin
        if (mem_ack) begin
          ack_ok  = 1'b1;
          state_d = RESP;
        end else if (cnt_q == CNT_LAST) begin
          timeout = 1'b1;
          fault_d = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fault_q <= fault_d;
    end
  end

  // Request fields are captured at accept so the bus sees stable values for the whole REQ phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      is_store_q  <= 1'b0;
      sign_ext_q  <= 1'b0;
      size_q      <= SIZE_B;
      off_q       <= 3'd0;
      mem_addr_q  <= '0;
      mem_be_q    <= 8'h00;
      mem_wdata_q <= '0;
      load_data_q <= '0;
    end else begin
      if (accept) begin
        is_store_q  <= is_store;
        sign_ext_q  <= sign_ext;
        size_q      <= size;
        off_q       <= addr[2:0];
        mem_addr_q  <= {addr[WORD-1:3], 3'b000};
        mem_be_q    <= size_mask(size) << addr[2:0];
        mem_wdata_q <= store_data << {addr[2:0], 3'b000};
      end
      if (ack_ok && !is_store_q) begin
        load_data_q <= ext_data;
      end
    end
  end

  load_extract u_extract (
    .mem_rdata (mem_rdata),
    .offset    (off_q),
    .size      (size_q),
    .sign_ext  (sign_ext_q),
    .load_data (ext_data)
  );

  assign mem_req   = (state_q == REQ);
  assign mem_we    = mem_req & is_store_q;
  assign mem_addr  = mem_addr_q;
  assign mem_be    = mem_be_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == RESP);
  assign fault     = fault_q;
  assign load_data = load_data_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: scoreboard of expected access results
// built from a byte-wise reference model, one task per scenario.
module tb_load_store_unit;
  import load_store_unit_pkg::*;

  localparam int TO = 16;

  logic        clk, rst_n, start, is_store, sign_ext, mem_req, mem_we, mem_ack, busy, done, fault;
  logic [1:0]  size;
  logic [63:0] addr, store_data, mem_addr, mem_wdata, mem_rdata, load_data;
  logic [7:0]  mem_be;

  typedef struct {
    int done_cyc; int req_cycles; bit got_req; bit stable; bit busy_in_req;
    logic [7:0] be; logic [63:0] addr; logic [63:0] wdata; logic [63:0] ld;
    logic we; logic fault; logic done_after; logic busy_after;
  } obs_t;

  typedef struct {
    int done_cyc; int req_cycles;
    logic [7:0] be; logic [63:0] addr; logic [63:0] wdata; logic [63:0] ld;
    logic we; logic fault;
  } exp_t;

  exp_t        sb[$];
  logic [63:0] model_ld;
  int          n_pass, n_total;

  load_store_unit #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .is_store(is_store), .size(size),
    .sign_ext(sign_ext), .addr(addr), .store_data(store_data), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .busy(busy), .done(done),
    .fault(fault), .load_data(load_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t make_exp(input logic st, input logic [1:0] sz, input logic sx,
                                    input logic [63:0] a, input logic [63:0] sd, input logic [63:0] rd,
                                    input int ack_cyc, input logic [63:0] prev_ld);
    exp_t e; int off; int nb; bit trap; bit ok; logic [63:0] v;
    off = int'(a[2:0]);
    nb  = 1 << sz;
`ifdef LSU_ALIGN_CHECK_EN
    trap = (off % nb) != 0;
`else
    trap = 1'b0;
`endif
    ok           = !trap && ack_cyc >= 1 && ack_cyc <= TO;
    e.done_cyc   = trap ? 1 : (ok ? ack_cyc + 1 : TO + 1);
    e.req_cycles = trap ? 0 : e.done_cyc - 1;
    e.fault      = !ok;
    e.addr       = a & ~64'h7;
    e.we         = st;
    e.be         = 8'h00;
    e.wdata      = '0;
    v            = '0;
    for (int i = 0; i < 8; i++) begin
      if (i >= off && i < off + nb) e.be[i] = 1'b1;
      if (i >= off) e.wdata[i*8 +: 8] = sd[(i-off)*8 +: 8];
      if (i < nb && off + i < 8) v[i*8 +: 8] = rd[(off+i)*8 +: 8];
    end
    if (sx && nb < 8 && v[8*nb-1]) for (int j = nb; j < 8; j++) v[j*8 +: 8] = 8'hFF;
    e.ld = (!st && ok) ? v : prev_ld;
    return e;
  endfunction

  task automatic run_access(input logic st, input logic [1:0] sz, input logic sx,
                            input logic [63:0] a, input logic [63:0] sd, input logic [63:0] rd,
                            input int ack_cyc, input bit poke, output obs_t o);
    o = '{default: 0};
    o.done_cyc = -1; o.stable = 1; o.busy_in_req = 1;
    is_store = st; size = sz; sign_ext = sx; addr = a; store_data = sd; mem_rdata = rd; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; is_store = ~st; size = ~sz; sign_ext = ~sx; addr = ~a; store_data = ~sd;
    for (int c = 1; c < 60; c++) begin
      if (done === 1'b1) begin
        o.done_cyc = c; o.ld = load_data; o.fault = fault;
        break;
      end
      if (mem_req === 1'b1) begin
        if (!o.got_req) begin
          o.got_req = 1; o.be = mem_be; o.addr = mem_addr; o.wdata = mem_wdata; o.we = mem_we;
        end else if ({mem_be, mem_addr, mem_wdata, mem_we} !== {o.be, o.addr, o.wdata, o.we}) begin
          o.stable = 0;
        end
        if (busy !== 1'b1) o.busy_in_req = 0;
        o.req_cycles++;
      end
      mem_ack = (c == ack_cyc);
      start   = poke && (c == 2);
      @(posedge clk); #1;
    end
    mem_ack = 1'b0; start = 1'b0;
    @(posedge clk); #1;
    o.done_after = done; o.busy_after = busy;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_total++; if ({mem_req, mem_we, busy, done, fault} !== 5'b0) $display("FAIL reset_ctrl got %b want 00000", {mem_req, mem_we, busy, done, fault}); else n_pass++;
    n_total++; if ({mem_be, mem_addr, mem_wdata, load_data} !== '0) $display("FAIL reset_data be=%h addr=%h wdata=%h ld=%h want all 0", mem_be, mem_addr, mem_wdata, load_data); else n_pass++;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    model_ld = '0;
    n_total++; if (busy !== 1'b0) $display("FAIL reset_release_busy got %b want 0", busy); else n_pass++;
  endtask

  task automatic test_load_dword();
    obs_t o; exp_t e;
    sb.push_back(make_exp(1'b0, SIZE_D, 1'b0, 64'h10, '0, 64'h1122334455667788, 3, model_ld));
    run_access(1'b0, SIZE_D, 1'b0, 64'h10, '0, 64'h1122334455667788, 3, 1'b0, o);
    e = sb.pop_front(); model_ld = e.ld;
    n_total++; if (o.be !== 8'hFF) $display("FAIL dword_be got %h want ff", o.be); else n_pass++;
    n_total++; if (o.ld !== e.ld) $display("FAIL dword_ld got %h want %h", o.ld, e.ld); else n_pass++;
    n_total++; if (o.done_cyc !== 4) $display("FAIL dword_done_cycle got %0d want 4", o.done_cyc); else n_pass++;
    n_total++; if (o.done_after !== 1'b0) $display("FAIL dword_done_pulse got %b want 0", o.done_after); else n_pass++;
  endtask

  task automatic test_load_word_sext();
    obs_t o; exp_t e;
    sb.push_back(make_exp(1'b0, SIZE_W, 1'b1, 64'h14, '0, 64'h80000001_00000000, 2, model_ld));
    run_access(1'b0, SIZE_W, 1'b1, 64'h14, '0, 64'h80000001_00000000, 2, 1'b0, o);
    e = sb.pop_front(); model_ld = e.ld;
    n_total++; if (o.be !== 8'hF0) $display("FAIL word_be got %h want f0", o.be); else n_pass++;
    n_total++; if (o.ld !== 64'hFFFFFFFF80000001) $display("FAIL word_sext_ld got %h want ffffffff80000001", o.ld); else n_pass++;
    n_total++; if (o.addr !== e.addr) $display("FAIL word_addr got %h want %h", o.addr, e.addr); else n_pass++;
  endtask

  task automatic test_store_byte();
    obs_t o; exp_t e;
    sb.push_back(make_exp(1'b1, SIZE_B, 1'b0, 64'h7, 64'hAB, 64'h5555, 1, model_ld));
    run_access(1'b1, SIZE_B, 1'b0, 64'h7, 64'hAB, 64'h5555, 1, 1'b0, o);
    e = sb.pop_front(); model_ld = e.ld;
    n_total++; if (o.be !== 8'h80) $display("FAIL store_be got %h want 80", o.be); else n_pass++;
    n_total++; if (o.wdata[63:56] !== 8'hAB) $display("FAIL store_wdata got %h want ab", o.wdata[63:56]); else n_pass++;
    n_total++; if (o.we !== 1'b1) $display("FAIL store_we got %b want 1", o.we); else n_pass++;
    n_total++; if (o.ld !== e.ld) $display("FAIL store_ld_kept got %h want %h", o.ld, e.ld); else n_pass++;
  endtask

  task automatic test_timeout();
    obs_t o; exp_t e;
    sb.push_back(make_exp(1'b0, SIZE_D, 1'b0, 64'h28, '0, 64'hDEAD, 0, model_ld));
    run_access(1'b0, SIZE_D, 1'b0, 64'h28, '0, 64'hDEAD, 0, 1'b0, o);
    e = sb.pop_front(); model_ld = e.ld;
    n_total++; if (o.req_cycles !== e.req_cycles) $display("FAIL timeout_req_cycles got %0d want %0d", o.req_cycles, e.req_cycles); else n_pass++;
    n_total++; if (o.done_cyc !== e.done_cyc) $display("FAIL timeout_done_cycle got %0d want %0d", o.done_cyc, e.done_cyc); else n_pass++;
    n_total++; if (o.fault !== 1'b1) $display("FAIL timeout_fault got %b want 1", o.fault); else n_pass++;
    n_total++; if (o.ld !== e.ld) $display("FAIL timeout_ld_kept got %h want %h", o.ld, e.ld); else n_pass++;
    repeat (3) @(posedge clk);
    #1;
    n_total++; if ({fault, mem_req} !== 2'b10) $display("FAIL fault_sticky fault/req got %b want 10", {fault, mem_req}); else n_pass++;
  endtask

  task automatic test_ack_at_limit();
    obs_t o; exp_t e;
    sb.push_back(make_exp(1'b0, SIZE_H, 1'b0, 64'h32, '0, 64'h0000_0000_1234_0000, TO, model_ld));
    run_access(1'b0, SIZE_H, 1'b0, 64'h32, '0, 64'h0000_0000_1234_0000, TO, 1'b0, o);
    e = sb.pop_front(); model_ld = e.ld;
    n_total++; if (o.fault !== 1'b0) $display("FAIL limit_ack_fault got %b want 0", o.fault); else n_pass++;
    n_total++; if (o.ld !== e.ld) $display("FAIL limit_ack_ld got %h want %h", o.ld, e.ld); else n_pass++;
  endtask

  task automatic test_ignored_inputs();
    obs_t o; exp_t e; bit bad;
    sb.push_back(make_exp(1'b0, SIZE_W, 1'b1, 64'h48, '0, 64'h0000_0000_8765_4321, 4, model_ld));
    run_access(1'b0, SIZE_W, 1'b1, 64'h48, '0, 64'h0000_0000_8765_4321, 4, 1'b1, o);
    e = sb.pop_front(); model_ld = e.ld;
    n_total++; if (o.done_cyc !== e.done_cyc) $display("FAIL busy_start_done got %0d want %0d", o.done_cyc, e.done_cyc); else n_pass++;
    n_total++; if ({o.stable, o.we} !== 2'b10) $display("FAIL busy_start_stable stable/we got %b want 10", {o.stable, o.we}); else n_pass++;
    n_total++; if (o.ld !== e.ld) $display("FAIL busy_start_ld got %h want %h", o.ld, e.ld); else n_pass++;
    bad = 0;
    mem_ack = 1'b1; mem_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
    repeat (3) begin
      @(posedge clk); #1;
      if (busy !== 1'b0 || done !== 1'b0 || load_data !== e.ld) bad = 1;
    end
    mem_ack = 1'b0;
    n_total++; if (bad !== 1'b0) $display("FAIL idle_ack_ignored got %b want 0", bad); else n_pass++;
  endtask

  task automatic test_reset_mid();
    obs_t o; exp_t e; bit saw_done;
    is_store = 1'b0; size = SIZE_D; sign_ext = 1'b0; addr = 64'h40; mem_rdata = 64'h77; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n_total++; if (mem_req !== 1'b1) $display("FAIL mid_reset_in_req got %b want 1", mem_req); else n_pass++;
    @(posedge clk); #1;
    rst_n = 1'b0; #1;
    n_total++; if ({mem_req, mem_we, busy, done, fault} !== 5'b0) $display("FAIL mid_reset_ctrl got %b want 00000", {mem_req, mem_we, busy, done, fault}); else n_pass++;
    n_total++; if ({mem_be, mem_addr, mem_wdata, load_data} !== '0) $display("FAIL mid_reset_data be=%h addr=%h wdata=%h ld=%h want all 0", mem_be, mem_addr, mem_wdata, load_data); else n_pass++;
    saw_done = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (done !== 1'b0) saw_done = 1;
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    model_ld = '0;
    n_total++; if (saw_done !== 1'b0) $display("FAIL mid_reset_no_done got %b want 0", saw_done); else n_pass++;
    sb.push_back(make_exp(1'b0, SIZE_H, 1'b1, 64'h22, '0, 64'h0000_0000_BEEF_0000, 1, model_ld));
    run_access(1'b0, SIZE_H, 1'b1, 64'h22, '0, 64'h0000_0000_BEEF_0000, 1, 1'b0, o);
    e = sb.pop_front(); model_ld = e.ld;
    n_total++; if ({o.ld, o.fault} !== {e.ld, e.fault}) $display("FAIL post_reset_load ld=%h f=%b want ld=%h f=%b", o.ld, o.fault, e.ld, e.fault); else n_pass++;
    n_total++; if (o.done_cyc !== 2) $display("FAIL post_reset_done got %0d want 2", o.done_cyc); else n_pass++;
  endtask

  task automatic test_misaligned();
    obs_t o; exp_t e;
`ifdef LSU_ALIGN_CHECK_EN
    sb.push_back(make_exp(1'b0, SIZE_H, 1'b0, 64'h3, '0, 64'hFFFF_0000, 5, model_ld));
    run_access(1'b0, SIZE_H, 1'b0, 64'h3, '0, 64'hFFFF_0000, 5, 1'b0, o);
    e = sb.pop_front(); model_ld = e.ld;
    n_total++; if (o.got_req !== 1'b0) $display("FAIL trap_no_req got %b want 0", o.got_req); else n_pass++;
    n_total++; if ({o.fault, o.done_cyc} !== {1'b1, 32'd1}) $display("FAIL trap_fault_done f=%b cyc=%0d want f=1 cyc=1", o.fault, o.done_cyc); else n_pass++;
    n_total++; if (o.ld !== e.ld) $display("FAIL trap_ld_kept got %h want %h", o.ld, e.ld); else n_pass++;
`else
    sb.push_back(make_exp(1'b0, SIZE_H, 1'b1, 64'h7, '0, 64'h9C00_0000_0000_0000, 2, model_ld));
    run_access(1'b0, SIZE_H, 1'b1, 64'h7, '0, 64'h9C00_0000_0000_0000, 2, 1'b0, o);
    e = sb.pop_front(); model_ld = e.ld;
    n_total++; if (o.be !== 8'h80) $display("FAIL misalign_be got %h want 80", o.be); else n_pass++;
    n_total++; if (o.ld !== 64'h9C) $display("FAIL misalign_ld got %h want 9c", o.ld); else n_pass++;
    n_total++; if (o.fault !== 1'b0) $display("FAIL misalign_fault got %b want 0", o.fault); else n_pass++;
`endif
  endtask

  task automatic test_back_to_back();
    obs_t o; exp_t e;
    logic st, sx; logic [1:0] sz; logic [63:0] a, sd, rd; int ak;
    for (int n = 0; n < 12; n++) begin
      st = 1'($urandom_range(0, 1)); sx = 1'($urandom_range(0, 1)); sz = 2'($urandom_range(0, 3));
      a  = {$urandom, $urandom}; sd = {$urandom, $urandom}; rd = {$urandom, $urandom};
      ak = $urandom_range(1, 4);
      sb.push_back(make_exp(st, sz, sx, a, sd, rd, ak, model_ld));
      run_access(st, sz, sx, a, sd, rd, ak, 1'b0, o);
      e = sb.pop_front(); model_ld = e.ld;
      n_total++; if (o.done_cyc !== e.done_cyc || o.req_cycles !== e.req_cycles) $display("FAIL b2b_timing[%0d] done=%0d req=%0d want done=%0d req=%0d", n, o.done_cyc, o.req_cycles, e.done_cyc, e.req_cycles); else n_pass++;
      n_total++; if ({o.ld, o.fault} !== {e.ld, e.fault}) $display("FAIL b2b_result[%0d] ld=%h f=%b want ld=%h f=%b", n, o.ld, o.fault, e.ld, e.fault); else n_pass++;
      if (o.got_req) begin
        n_total++; if ({o.be, o.addr, o.wdata, o.we} !== {e.be, e.addr, e.wdata, e.we}) $display("FAIL b2b_bus[%0d] be=%h a=%h wd=%h we=%b want be=%h a=%h wd=%h we=%b", n, o.be, o.addr, o.wdata, o.we, e.be, e.addr, e.wdata, e.we); else n_pass++;
      end
      n_total++; if ({o.stable, o.busy_in_req, o.done_after, o.busy_after} !== 4'b1100) $display("FAIL b2b_handshake[%0d] got %b want 1100", n, {o.stable, o.busy_in_req, o.done_after, o.busy_after}); else n_pass++;
    end
  endtask

  initial begin
    n_pass = 0; n_total = 0; model_ld = '0;
    rst_n = 1'b0; start = 1'b0; is_store = 1'b0; size = SIZE_B; sign_ext = 1'b0;
    addr = '0; store_data = '0; mem_rdata = '0; mem_ack = 1'b0;
    test_reset();
    test_load_dword();
    test_load_word_sext();
    test_store_byte();
    test_timeout();
    test_ack_at_limit();
    test_ignored_inputs();
    test_reset_mid();
    test_misaligned();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish, passed %0d of %0d", n_pass, n_total);
    $fatal(1);
  end

endmodule
